des_ahb_slave: RTL and testbench

- AHB-Lite slave front end for the Triple DES core. It is the peer of the default slave on the same 64-bit bus and sits upstream of the 3DES datapath.
- Holds three 64-bit keys, the input block and the control/status registers. Issues a start pulse to the core and captures the core's result.
- Out-of-map, misaligned and wrong-size accesses receive the standard two-cycle ERROR response, as the default slave gives.

---
 rtl/des_ahb_slave.sv | 180 ++++++++++++++++++
 tb/tb_des_ahb_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/des_ahb_slave.sv
// rtl/des_ahb_slave.sv - AHB-Lite register front end for the Triple DES core.
// Holds the key, data and control/status registers, and issues the start pulse to the core.
module des_ahb_slave #(
    parameter int OFFSET_BITS = 6
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HADDR,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [63:0] core_key1,
    output logic [63:0] core_key2,
    output logic [63:0] core_key3,
    output logic [63:0] core_data_in,
    input  logic        core_done,
    input  logic [63:0] core_data_out
);

    localparam logic [OFFSET_BITS-1:0] OFF_KEY1   = OFFSET_BITS'('h00);
    localparam logic [OFFSET_BITS-1:0] OFF_KEY2   = OFFSET_BITS'('h08);
    localparam logic [OFFSET_BITS-1:0] OFF_KEY3   = OFFSET_BITS'('h10);
    localparam logic [OFFSET_BITS-1:0] OFF_DIN    = OFFSET_BITS'('h18);
    localparam logic [OFFSET_BITS-1:0] OFF_CTRL   = OFFSET_BITS'('h20);
    localparam logic [OFFSET_BITS-1:0] OFF_STATUS = OFFSET_BITS'('h28);
    localparam logic [OFFSET_BITS-1:0] OFF_DOUT   = OFFSET_BITS'('h30);

    typedef enum logic [1:0] {S_OKAY, S_STALL, S_ERR1, S_ERR2} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_dp_valid;
    logic                   r_dp_write;
    logic [OFFSET_BITS-1:0] r_dp_off;
    logic [63:0]            r_key1, r_key2, r_key3, r_din, r_dout;
    logic                   r_decrypt, r_start, r_busy, r_done;

    logic [OFFSET_BITS-1:0] w_addr_off;
    logic                   w_accept, w_err, w_stall, w_wr_en, w_start_wr, w_busy_nxt;
    logic [63:0]            w_rdata;
    logic                   w_unused_ok;

    assign w_unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:OFFSET_BITS]};

    assign w_addr_off = HADDR[OFFSET_BITS-1:0];
    assign w_accept   = HSEL && HREADY && HTRANS[1];
    assign w_err      = (HSIZE != 3'b011) || (HADDR[2:0] != 3'b000) || (w_addr_off > OFF_DOUT) ||
                        (HWRITE && ((w_addr_off == OFF_STATUS) || (w_addr_off == OFF_DOUT)));

    // Register writes commit at the end of an OKAY data phase; STALL holds them off.
    assign w_wr_en    = (r_state == S_OKAY) && r_dp_valid && r_dp_write;
    assign w_start_wr = w_wr_en && (r_dp_off == OFF_CTRL) && HWDATA[0];

    // Look ahead at BUSY so a write pipelined right behind a START still stalls.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_start_wr)
            w_busy_nxt = 1'b1;
        else if (core_done)
            w_busy_nxt = 1'b0;
    end

    assign w_stall = HWRITE && (w_addr_off <= OFF_CTRL) && w_busy_nxt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_state <= S_OKAY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            S_OKAY, S_ERR2: begin
                HRESP = (r_state == S_ERR2);
                if (w_accept && w_err)
                    w_state_nxt = S_ERR1;
                else if (w_accept && w_stall)
                    w_state_nxt = S_STALL;
                else
                    w_state_nxt = S_OKAY;
            end
            S_STALL: begin
                HREADYOUT   = 1'b0;
                w_state_nxt = w_busy_nxt ? S_STALL : S_OKAY;
            end
            S_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = S_ERR2;
            end
            default: w_state_nxt = S_OKAY;
        endcase
    end

    // Data-phase address/control only advances when the bus is ready.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_off   <= '0;
        end else if (HREADY) begin
            r_dp_valid <= w_accept && !w_err;
            r_dp_write <= HWRITE;
            r_dp_off   <= w_addr_off;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_key1    <= '0;
            r_key2    <= '0;
            r_key3    <= '0;
            r_din     <= '0;
            r_dout    <= '0;
            r_decrypt <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start <= w_start_wr;
            r_busy  <= w_busy_nxt;
            if (w_wr_en) begin
                case (r_dp_off)
                    OFF_KEY1: r_key1    <= HWDATA;
                    OFF_KEY2: r_key2    <= HWDATA;
                    OFF_KEY3: r_key3    <= HWDATA;
                    OFF_DIN:  r_din     <= HWDATA;
                    OFF_CTRL: r_decrypt <= HWDATA[1];
                    default: ;
                endcase
            end
            if (w_start_wr)
                r_done <= 1'b0;
            else if (core_done && r_busy)
                r_done <= 1'b1;
            if (core_done && r_busy)
                r_dout <= core_data_out;
        end
    end

    always_comb begin
        w_rdata = '0;
        if ((r_state == S_OKAY) && r_dp_valid && !r_dp_write) begin
            case (r_dp_off)
                OFF_KEY1:   w_rdata = r_key1;
                OFF_KEY2:   w_rdata = r_key2;
                OFF_KEY3:   w_rdata = r_key3;
                OFF_DIN:    w_rdata = r_din;
                OFF_CTRL:   w_rdata = {62'd0, r_decrypt, 1'b0};
                OFF_STATUS: w_rdata = {62'd0, r_done, r_busy};
                OFF_DOUT:   w_rdata = r_dout;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign HRDATA       = w_rdata;
    assign core_start   = r_start;
    assign core_decrypt = r_decrypt;
    assign core_key1    = r_key1;
    assign core_key2    = r_key2;
    assign core_key3    = r_key3;
    assign core_data_in = r_din;

endmodule

// File: tb/tb_des_ahb_slave.sv
// tb/tb_des_ahb_slave.sv - directed self-checking bench for des_ahb_slave.
module tb_des_ahb_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] core_key1, core_key2, core_key3, core_data_in;
    logic        core_done;
    logic [63:0] core_data_out;
    wire         HREADY = HREADYOUT;

    int tests  = 0;
    int failed = 0;

    logic        e_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr [4] = '{32'h00, 32'h04, 32'h38, 32'h28};
    logic [2:0]  e_size [4] = '{3'b010, 3'b011, 3'b011, 3'b011};

    des_ahb_slave #(.OFFSET_BITS(6)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .core_start(core_start),
        .core_decrypt(core_decrypt), .core_key1(core_key1), .core_key2(core_key2),
        .core_key3(core_key3), .core_data_in(core_data_in), .core_done(core_done),
        .core_data_out(core_data_out)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; returns when the data phase is in its final (ready) cycle.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [63:0] wdata, output logic [63:0] rdata,
                            output int waits, output logic [1:0] first_rr,
                            output logic [1:0] last_rr);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'b011;
        HWDATA = wdata;
        waits    = 0;
        first_rr = {HREADYOUT, HRESP};
        while (HREADYOUT !== 1'b1 && waits < 64) begin
            @(posedge HCLK); #1;
            waits++;
        end
        rdata   = HRDATA;
        last_rr = {HREADYOUT, HRESP};
    endtask

    task automatic rd(input logic [31:0] addr, input logic [63:0] exp, input string tag);
        logic [63:0] d;
        int          w;
        logic [1:0]  f, l;
        ahb_xfer(1'b0, addr, 3'b011, 64'h0, d, w, f, l);
        check({tag, " data"}, d, exp);
        check({tag, " waits"}, 64'(w), 64'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [63:0] data, input string tag);
        logic [63:0] d;
        int          w;
        logic [1:0]  f, l;
        ahb_xfer(1'b1, addr, 3'b011, data, d, w, f, l);
        check({tag, " resp"}, {62'd0, l}, 64'h2);
    endtask

    task automatic done_pulse(input logic [63:0] data);
        @(posedge HCLK); #1;
        core_done = 1'b1; core_data_out = data;
        @(posedge HCLK); #1;
        core_done = 1'b0; core_data_out = '0;
    endtask

    initial begin
        logic [63:0] d;
        int          w;
        logic [1:0]  f, l;

        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b011;
        HBURST = 3'b000; HPROT = 4'h3; HMASTLOCK = 1'b0; HADDR = '0; HWDATA = '0;
        core_done = 1'b0; core_data_out = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("rst hresp", {63'd0, HRESP}, 64'd0);
        check("rst hrdata", HRDATA, 64'd0);
        check("rst core_start", {63'd0, core_start}, 64'd0);
        HRESET = 1'b0;

        wr(32'h00, 64'h0123456789ABCDEF, "wr key1");
        wr(32'h18, 64'hFEDCBA9876543210, "wr din");
        rd(32'h00, 64'h0123456789ABCDEF, "rd key1");
        rd(32'h18, 64'hFEDCBA9876543210, "rd din");
        check("core_key1", core_key1, 64'h0123456789ABCDEF);
        check("core_data_in", core_data_in, 64'hFEDCBA9876543210);

        wr(32'h20, 64'h3, "wr ctrl start dec");
        check("start before", {63'd0, core_start}, 64'd0);
        @(posedge HCLK); #1;
        check("start pulse", {63'd0, core_start}, 64'd1);
        check("decrypt", {63'd0, core_decrypt}, 64'd1);
        @(posedge HCLK); #1;
        check("start after", {63'd0, core_start}, 64'd0);
        rd(32'h28, 64'h1, "status busy");
        rd(32'h30, 64'h0, "dout while busy");
        rd(32'h20, 64'h2, "rd ctrl");
        done_pulse(64'h85E813540F0AB405);
        rd(32'h28, 64'h2, "status done");
        rd(32'h30, 64'h85E813540F0AB405, "dout");

        wr(32'h20, 64'h1, "wr ctrl start enc");
        @(posedge HCLK); #1;
        check("start pulse 2", {63'd0, core_start}, 64'd1);
        check("encrypt", {63'd0, core_decrypt}, 64'd0);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08; HSIZE = 3'b011;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HWDATA = 64'h1111111111111111;
        check("stall c1 rdy", {63'd0, HREADYOUT}, 64'd0);
        check("stall c1 resp", {63'd0, HRESP}, 64'd0);
        @(posedge HCLK); #1;
        check("stall c2 rdy", {63'd0, HREADYOUT}, 64'd0);
        core_done = 1'b1; core_data_out = 64'hA5A5A5A55A5A5A5A;
        @(posedge HCLK); #1;
        core_done = 1'b0; core_data_out = '0;
        check("stall release rdy", {63'd0, HREADYOUT}, 64'd1);
        check("key2 pending", core_key2, 64'd0);
        rd(32'h08, 64'h1111111111111111, "rd key2");
        check("core_key2", core_key2, 64'h1111111111111111);
        rd(32'h30, 64'hA5A5A5A55A5A5A5A, "dout 2");
        rd(32'h28, 64'h2, "status done 2");

        for (int i = 0; i < 4; i++) begin
            ahb_xfer(e_wr[i], e_addr[i], e_size[i], 64'hDEADBEEFDEADBEEF, d, w, f, l);
            check($sformatf("err%0d first", i), {62'd0, f}, 64'h1);
            check($sformatf("err%0d last", i), {62'd0, l}, 64'h3);
            check($sformatf("err%0d waits", i), 64'(w), 64'd1);
        end
        rd(32'h00, 64'h0123456789ABCDEF, "key1 after err");
        rd(32'h28, 64'h2, "status after err");

        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h00; HWDATA = 64'hCAFE;
        check("idle rdy", {63'd0, HREADYOUT}, 64'd1);
        @(posedge HCLK); #1;
        HTRANS = 2'b01;
        check("idle resp", {63'd0, HRESP}, 64'd0);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        check("busy-trans rdy", {63'd0, HREADYOUT}, 64'd1);
        check("busy-trans resp", {63'd0, HRESP}, 64'd0);
        rd(32'h00, 64'h0123456789ABCDEF, "key1 after idle");

        done_pulse(64'hFFFFFFFFFFFFFFFF);
        rd(32'h30, 64'hA5A5A5A55A5A5A5A, "dout stray done");

        wr(32'h20, 64'h3, "wr ctrl start 3");
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'b011;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HWDATA = 64'h2222222222222222;
        check("stall3 rdy", {63'd0, HREADYOUT}, 64'd0);
        #2 HRESET = 1'b1;
        #1;
        check("arst hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("arst hresp", {63'd0, HRESP}, 64'd0);
        check("arst hrdata", HRDATA, 64'd0);
        check("arst core_start", {63'd0, core_start}, 64'd0);
        check("arst decrypt", {63'd0, core_decrypt}, 64'd0);
        check("arst key1", core_key1, 64'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0; HWDATA = '0;
        rd(32'h28, 64'h0, "status after rst");
        done_pulse(64'h7777777777777777);
        rd(32'h28, 64'h0, "status rst done");
        rd(32'h30, 64'h0, "dout rst done");
        rd(32'h10, 64'h0, "key3 after rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
